fpmul_seq: RTL
==============

Name: fpmul_seq

Overview:
- Parametrised, self-sequenced IEEE-754-style floating-point multiplier.
- Successor to the fixed single-precision multiplier datapath and its separate control unit. Datapath and FSM are merged here, exponent and mantissa widths are generic, and rounding is round-to-nearest-even.
- Sits behind a start/done handshake. One operation in flight at a time.

Parameters:
- EXP_W, 8, exponent field width (≥3); bias = 2^(EXP_W-1)-1
- MAN_W, 23, stored fraction width (≥2); word width W = 1+EXP_W+MAN_W

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only when ready=1
- a  in  W  operand A, sampled on the accepting edge
- b  in  W  operand B, sampled on the accepting edge
- ready  out  1  high in IDLE only
- done  out  1  one-cycle pulse; p and flags are valid in that cycle
- p  out  W  product; held until the next result is loaded
- nan_f  out  1  p is NaN
- inf_f  out  1  p is ±inf
- zero_f  out  1  p is ±0
- dnf_f  out  1  at least one input was denormal and was flushed to zero
- of_f  out  1  exponent overflow occurred; p forced to ±inf
- uf_f  out  1  exponent underflow occurred; p flushed to ±0

Behaviour:
- Reset (rst=0, any state, takes effect immediately):
  - state=IDLE, ready=1, done=0.
  - p=0 and all flags=0.
  - Any in-flight operation is discarded; no done is issued for it.
- FSM states: IDLE → CLASS → MUL → NORM → RND → FIN → IDLE.
- IDLE: start=1 registers a and b and moves to CLASS. start in any other state is ignored.
- CLASS (classify both operands):
  - exp all-ones with frac≠0 is NaN; exp all-ones with frac=0 is inf.
  - exp=0 is zero. Denormals (exp=0, frac≠0) are treated as zero and set dnf_f.
  - Sign of the result = sa XOR sb.
  - Special cases go directly to FIN:
    - Any NaN, or inf×0 → canonical qNaN: sign 0, exp all ones, frac MSB 1, rest 0.
    - inf×(finite nonzero or inf) → ±inf.
    - 0×(finite or 0) → ±0.
  - Otherwise go to MUL.
- MUL:
  - Mantissa product = {1,fa}×{1,fb}, 2(MAN_W+1) bits.
  - Exponent = ea+eb-bias, computed signed in EXP_W+2 bits.
- NORM: if product MSB=1, shift right 1 and add 1 to the exponent. Extract guard bit G and sticky bit S (OR of all lower bits).
- RND:
  - Round up iff G & (S | LSB).
  - If the mantissa carries out, shift right 1 and add 1 to the exponent.
- Load into FIN (exponent after rounding):
  - exp ≥ 2^EXP_W-1 → ±inf, of_f=1.
  - exp ≤ 0 → ±0, uf_f=1. No denormal outputs are produced.
  - Otherwise p is packed from sign, exp[EXP_W-1:0] and frac.
- FIN: done=1 for exactly one cycle, then IDLE (ready=1 in the next cycle). Back-to-back start is allowed from that cycle.
- Latency (start accepted at the end of cycle 0):
  - done=1 in cycle 5 for the normal path.
  - done=1 in cycle 2 for the special path.
- Output registers (p and all flags):
  - Loaded only on entry to FIN.
  - Flags are cleared at the start of each accepted operation and reflect only that operation.
  - nan_f, inf_f and zero_f describe the final p, including overflow and underflow results.

Test Plan:
- Default params: a=0x3FC00000 (1.5), b=0x40000000 (2.0), start in cycle 0 → done in cycle 5, p=0x40400000, all flags 0; ready=0 during cycles 1–5.
- a=0x7F800000 (inf), b=0x00000000 → done in cycle 2, p=0x7FC00000, nan_f=1; a=0xC0000000, b=0x3F800000 → p=0xC0000000.
- a=b=0x3F800800 (1+2^-12) → exact tie → RNE keeps even, p=0x3F801000.
- a=b=0x7F000000 → p=0x7F800000, of_f=1, inf_f=1. a=b=0x00800000 → p=0x00000000, uf_f=1, zero_f=1.
- a=0x00000001 (denormal), b=0x3F800000 → p=0x00000000, dnf_f=1, zero_f=1. Pull rst low in cycle 3 of a normal operation → done never pulses, p=0, ready=1 immediately.
- EXP_W=5, MAN_W=10: a=0x3E00 (1.5), b=0x4000 (2.0) → done in cycle 5, p=0x4200; start held high continuously → a new operation is accepted each time ready=1.

Source files
------------

// File: rtl/fpmul_seq.sv
// Sequential floating-point multiplier with generic exponent/fraction widths,
// round-to-nearest-even, flush-to-zero of denormals, start/done handshake.
module fpmul_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ready,
  output logic         done,
  output logic [W-1:0] p,
  output logic         nan_f,
  output logic         inf_f,
  output logic         zero_f,
  output logic         dnf_f,
  output logic         of_f,
  output logic         uf_f
);

  localparam int M  = MAN_W + 1;
  localparam int PW = 2 * M;
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] BIAS_S  = EW'(2**(EXP_W-1) - 1);
  localparam logic signed [EW-1:0] EXP_MAX = EW'(2**EXP_W - 1);
  localparam logic signed [EW-1:0] ONE_S   = EW'(1);
  localparam logic [EXP_W-1:0]     EXP_ONES = '1;
  localparam logic [W-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_CLASS, S_MUL, S_NORM, S_RND, S_FIN
  } state_t;

  state_t                state_q, state_d;
  logic [W-1:0]          a_q, a_d, b_q, b_d, p_q, p_d;
  logic signed [EW-1:0]  exp_q, exp_d;
  logic [PW-1:0]         prod_q, prod_d;
  logic [M-1:0]          mant_q, mant_d;
  logic                  g_q, g_d, s_q, s_d;
  // {nan, inf, zero, dnf, of, uf}
  logic [5:0]            flags_q, flags_d;

  logic [EXP_W-1:0]      ea, eb;
  logic [MAN_W-1:0]      fa, fb, frac_r;
  logic                  sgn, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, dn_a, dn_b;
  logic signed [EW-1:0]  ea_s, eb_s, exp_r;
  logic [M:0]            sum;
  logic                  rnd_up;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      exp_q   <= '0;
      prod_q  <= '0;
      mant_q  <= '0;
      g_q     <= 1'b0;
      s_q     <= 1'b0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      exp_q   <= exp_d;
      prod_q  <= prod_d;
      mant_q  <= mant_d;
      g_q     <= g_d;
      s_q     <= s_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    exp_d   = exp_q;
    prod_d  = prod_q;
    mant_d  = mant_q;
    g_d     = g_q;
    s_d     = s_q;
    flags_d = flags_q;
    ready   = (state_q == S_IDLE);
    done    = (state_q == S_FIN);

    ea     = a_q[W-2:MAN_W];
    eb     = b_q[W-2:MAN_W];
    fa     = a_q[MAN_W-1:0];
    fb     = b_q[MAN_W-1:0];
    sgn    = a_q[W-1] ^ b_q[W-1];
    nan_a  = (ea == EXP_ONES) && (fa != '0);
    nan_b  = (eb == EXP_ONES) && (fb != '0);
    inf_a  = (ea == EXP_ONES) && (fa == '0);
    inf_b  = (eb == EXP_ONES) && (fb == '0);
    zero_a = (ea == '0);
    zero_b = (eb == '0);
    dn_a   = zero_a && (fa != '0);
    dn_b   = zero_b && (fb != '0);
    ea_s   = {2'b00, ea};
    eb_s   = {2'b00, eb};

    rnd_up = g_q & (s_q | mant_q[0]);
    sum    = {1'b0, mant_q} + {{M{1'b0}}, rnd_up};
    exp_r  = sum[M] ? exp_q + ONE_S : exp_q;
    frac_r = sum[M] ? sum[MAN_W:1] : sum[MAN_W-1:0];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          flags_d = '0;
          state_d = S_CLASS;
        end
      end
      S_CLASS: begin
        state_d = S_FIN;
        if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) begin
          p_d     = QNAN;
          flags_d = {3'b100, dn_a | dn_b, 2'b00};
        end else if (inf_a || inf_b) begin
          p_d     = {sgn, EXP_ONES, {MAN_W{1'b0}}};
          flags_d = {3'b010, dn_a | dn_b, 2'b00};
        end else if (zero_a || zero_b) begin
          p_d     = {sgn, {(W-1){1'b0}}};
          flags_d = {3'b001, dn_a | dn_b, 2'b00};
        end else begin
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        prod_d  = PW'({1'b1, fa}) * PW'({1'b1, fb});
        exp_d   = ea_s + eb_s - BIAS_S;
        state_d = S_NORM;
      end
      S_NORM: begin
        // On the right shift the bit below guard joins the sticky OR.
        if (prod_q[PW-1]) begin
          mant_d = prod_q[PW-1 -: M];
          g_d    = prod_q[PW-1-M];
          s_d    = |prod_q[PW-2-M:0];
          exp_d  = exp_q + ONE_S;
        end else begin
          mant_d = prod_q[PW-2 -: M];
          g_d    = prod_q[PW-2-M];
          s_d    = |prod_q[PW-3-M:0];
        end
        state_d = S_RND;
      end
      S_RND: begin
        if (exp_r >= EXP_MAX) begin
          p_d     = {sgn, EXP_ONES, {MAN_W{1'b0}}};
          flags_d = 6'b010010;
        end else if (exp_r[EW-1] || (exp_r == '0)) begin
          p_d     = {sgn, {(W-1){1'b0}}};
          flags_d = 6'b001001;
        end else begin
          p_d     = {sgn, exp_r[EXP_W-1:0], frac_r};
          flags_d = '0;
        end
        state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign p      = p_q;
  assign nan_f  = flags_q[5];
  assign inf_f  = flags_q[4];
  assign zero_f = flags_q[3];
  assign dnf_f  = flags_q[2];
  assign of_f   = flags_q[1];
  assign uf_f   = flags_q[0];

endmodule
